instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encoder counterpart of the core's instruction decoder. Accepts compact instruction descriptors over a valid/ready handshake.
- Packs each descriptor into a 32-bit RV32I word (ADDI or BNE, the two opcodes the core executes).
- Writes the words to consecutive instruction-memory addresses through a single write port.
- Used to load test programs into instruction memory before the core runs.

Parameters:
- AW, 32, instruction word width (only 32 supported).
- ADDR_WIDTH, 8, instruction-memory word-address width. Capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse: clears the address counter and begins a program load
- in_valid  input  1  descriptor valid
- in_ready  output  1  encoder can accept a descriptor
- in_op  input  2  00 ADDI, 01 BNE, 10 HALT (end of program), 11 reserved
- in_rd  input  5  destination register (ADDI)
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2 (BNE)
- in_imm  input  12  ADDI: imm[11:0]. BNE: byte offset bits imm[12:1] (imm[0] is implicitly 0).
- wr_en  output  1  instruction-memory write strobe
- wr_addr  output  ADDR_WIDTH  word address for the write
- wr_data  output  AW  encoded instruction
- word_count  output  ADDR_WIDTH+1  number of words written since the last start
- done  output  1  load finished (HALT received or memory full)
- full  output  1  load ended because memory capacity was reached
- err  output  1  reserved op received

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE; in_ready, wr_en, done, full and err all 0; wr_addr, wr_data and word_count all 0.
- States are IDLE, RUN, WRITE, DONE and ERR.
  - IDLE: in_ready=0. start leads to RUN.
  - RUN: in_ready=1. A transfer occurs on in_valid&&in_ready.
    - ADDI or BNE: register the encoded word into wr_data, then go to WRITE.
    - HALT: go to DONE; nothing is written.
    - Reserved op: go to ERR.
  - WRITE: in_ready=0 and wr_en=1 for exactly this one cycle, with wr_addr equal to the current address.
    - On exit, address increments and word_count increments.
    - If the address written was 2^ADDR_WIDTH-1, go to DONE and set full=1. Otherwise return to RUN.
  - DONE: done=1, held until start or rst. in_ready=0.
  - ERR: err=1, held until start or rst. in_ready=0.
- Latency and throughput:
  - A transfer accepted in cycle N produces wr_en in cycle N+1.
  - Maximum throughput is one descriptor per 2 cycles.
- start handling:
  - start has priority below rst, in every state. Entering RUN clears address, word_count, done, full and err.
  - start during WRITE aborts that write: wr_en stays 0 in the following cycle.
  - start together with in_valid in RUN: start wins and the descriptor is not accepted (in_ready forced to 0 that cycle).
- Encoding (bit fields, MSB first):
  - ADDI: imm[11:0] | rs1 | 000 | rd | 0010011 (opcode 19).
  - BNE: imm[12] | imm[10:5] | rs2 | rs1 | 001 | imm[4:1] | imm[11] | 1100011 (opcode 99).
  - Unused fields in the descriptor are ignored.
- Back-pressure: in_ready is purely a function of the registered state (and start). There is no combinational path from in_valid to in_ready.
- wr_data holds its last value outside WRITE.

Decomposition:
- Package rv_enc_pkg holds:
  - OPC_ADDI=7'd19, OPC_BNE=7'd99.
  - F3_ADDI=3'b000, F3_BNE=3'b001.
  - enc_op_t enum: ADDI, BNE, HALT, RSVD.
  - enc_state_t enum: IDLE, RUN, WRITE, DONE, ERR.
- Sub-module instr_pack: purely combinational. Maps (op, rd, rs1, rs2, imm) to a 32-bit word. The bench reuses it as the reference model.

Test Plan:
- rst, start, ADDI rd=1 rs1=0 imm=5 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00500093; word_count=1.
- ADDI as above, then BNE rs1=1 rs2=2 in_imm=0xFFE (offset -4) -> wr_addr=1, wr_data=0xFE209EE3; in_ready low during each WRITE cycle.
- 3 descriptors then HALT -> exactly 3 writes at addr 0..2; done=1 and full=0 held; in_ready=0 until the next start.
- ADDR_WIDTH=2, with in_valid held high for 5 ADDI descriptors -> writes at addr 0..3, then done=1, full=1, word_count=4; the 5th descriptor is never accepted.
- in_op=11 -> err=1, no wr_en; then start -> err=0, the next ADDI is written at addr 0.
- start asserted in the WRITE cycle -> no wr_en that cycle; the next descriptor is written to addr 0. rst mid-RUN -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared encodings for the RV32I instruction encoder: opcodes, funct3 values,
// the descriptor op enumeration and the load-controller state enumeration.
package rv_enc_pkg;

  localparam logic [6:0] OPC_ADDI = 7'd19;
  localparam logic [6:0] OPC_BNE  = 7'd99;
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;

  typedef enum logic [1:0] {
    ADDI = 2'b00,
    BNE  = 2'b01,
    HALT = 2'b10,
    RSVD = 2'b11
  } enc_op_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WRITE,
    DONE,
    ERR
  } enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor handshake between a program source (master) and the encoder (slave).
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [11:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: turns one ADDI/BNE descriptor into its 32-bit RV32I word.
module instr_pack
  import rv_enc_pkg::*;
(
  input  enc_op_t     op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  // For BNE, imm carries offset bits [12:1], so imm[k] is offset bit k+1.
  always_comb begin
    word = '0;
    case (op)
      ADDI:    word = {imm, rs1, F3_ADDI, rd, OPC_ADDI};
      BNE:     word = {imm[11], imm[9:4], rs2, rs1, F3_BNE, imm[3:0], imm[10], OPC_BNE};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts descriptors, encodes them and writes the words to
// consecutive instruction-memory addresses until HALT, a reserved op, or memory full.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int AW         = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_if.slave        in_if,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [AW-1:0]         wr_data,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  full,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  enc_state_t  state;
  enc_op_t     op;
  logic        wr_en_q;
  logic        xfer;
  logic [31:0] packed_word;

  assign op = enc_op_t'(in_if.in_op);

  instr_pack u_pack (
    .op   (op),
    .rd   (in_if.in_rd),
    .rs1  (in_if.in_rs1),
    .rs2  (in_if.in_rs2),
    .imm  (in_if.in_imm),
    .word (packed_word)
  );

  // start overrides both the handshake and a pending write in the same cycle.
  assign in_if.in_ready = (state == RUN) && !start;
  assign wr_en          = wr_en_q && !start;
  assign xfer           = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_en_q    <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
    end else if (start) begin
      state      <= RUN;
      wr_en_q    <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
      err        <= 1'b0;
      wr_addr    <= '0;
      word_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (xfer) begin
            case (op)
              ADDI, BNE: begin
                wr_data <= packed_word;
                wr_en_q <= 1'b1;
                state   <= WRITE;
              end
              HALT: begin
                done  <= 1'b1;
                state <= DONE;
              end
              default: begin
                err   <= 1'b1;
                state <= ERR;
              end
            endcase
          end
        end
        WRITE: begin
          wr_en_q    <= 1'b0;
          wr_addr    <= wr_addr + 1'b1;
          word_count <= word_count + 1'b1;
          if (wr_addr == ADDR_LAST) begin
            done  <= 1'b1;
            full  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        IDLE, DONE, ERR: state <= state;
        default:         state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a wide instance for program loads and a
// 4-word instance for the memory-full path.
module tb_instr_encoder;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        wr_en, wr_en_s;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_addr_s;
  logic [31:0] wr_data, wr_data_s;
  logic [8:0]  word_count;
  logic [2:0]  word_count_s;
  logic        done, full, err, done_s, full_s, err_s;

  int   total = 0;
  int   bad = 0;
  int   nwr = 0;
  int   nwr_s = 0;
  int   nxt_addr = 0;
  int   nxt_addr_s = 0;
  exp_t exp_q[$];
  exp_t exp_qs[$];

  instr_encoder_if bus ();
  instr_encoder_if bus_s ();

  always #5 clk = ~clk;

  instr_encoder #(.AW(32), .ADDR_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_if(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .word_count(word_count),
    .done(done), .full(full), .err(err)
  );

  instr_encoder #(.AW(32), .ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .start(start_s), .in_if(bus_s),
    .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s), .word_count(word_count_s),
    .done(done_s), .full(full_s), .err(err_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the ISA field layout, using plain integer arithmetic.
  function automatic logic [31:0] ref_addi(input int rd, input int rs1, input int imm);
    int unsigned w;
    w = ((imm & 32'hFFF) << 20) + (rs1 << 15) + (rd << 7) + 19;
    return w;
  endfunction

  function automatic logic [31:0] ref_bne(input int rs1, input int rs2, input int off);
    int unsigned u, w;
    u = off & 32'h1FFF;
    w = (((u >> 12) & 1) << 31) + (((u >> 5) & 63) << 25) + (rs2 << 20) + (rs1 << 15)
      + (1 << 12) + (((u >> 1) & 15) << 8) + (((u >> 11) & 1) << 7) + 99;
    return w;
  endfunction

  // Monitors: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      nwr++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {56'd0, wr_addr}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {56'd0, wr_addr}, e.addr);
        chk("wr_data", {32'd0, wr_data}, {32'd0, e.data});
        chk("word_count_in_write", {55'd0, word_count}, e.addr);
        chk("ready_in_write", {63'd0, bus.in_ready}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_en_s) begin
      nwr_s++;
      if (exp_qs.size() == 0) begin
        chk("small_unexpected_write_addr", {62'd0, wr_addr_s}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_qs.pop_front();
        chk("small_wr_addr", {62'd0, wr_addr_s}, e.addr);
        chk("small_wr_data", {32'd0, wr_data_s}, {32'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_q.delete();
    nxt_addr = 0;
    tick();
    start = 1'b0;
  endtask

  // Presents one descriptor and holds it until accepted; exp is the word it must encode to.
  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, input logic [31:0] exp);
    bit acc;
    bus.in_op = op; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        if (op == 2'b00 || op == 2'b01) begin
          exp_q.push_back('{addr: nxt_addr, data: exp});
          nxt_addr++;
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_rand();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [12:0] o13;
    int          off;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    if ($urandom_range(0, 1) == 0) begin
      off = int'($urandom_range(0, 4095)) - 2048;
      imm = off[11:0];
      send(2'b00, rd, rs1, rs2, imm, ref_addi(rd, rs1, off));
    end else begin
      off = int'($urandom_range(0, 4095)) * 2 - 4096;
      o13 = off[12:0];
      imm = o13[12:1];
      send(2'b01, rd, rs1, rs2, imm, ref_bne(rs1, rs2, off));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int acc_s;
    bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
    bus_s.in_valid = 0; bus_s.in_op = 0; bus_s.in_rd = 0; bus_s.in_rs1 = 0; bus_s.in_rs2 = 0; bus_s.in_imm = 0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.in_ready}, 0);
    chk("rst_wr_en", {63'd0, wr_en}, 0);
    chk("rst_done", {63'd0, done}, 0);
    chk("rst_full", {63'd0, full}, 0);
    chk("rst_err", {63'd0, err}, 0);
    chk("rst_wr_addr", {56'd0, wr_addr}, 0);
    chk("rst_wr_data", {32'd0, wr_data}, 0);
    chk("rst_word_count", {55'd0, word_count}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Directed ADDI then BNE
    do_start();
    send(2'b00, 5'd1, 5'd0, 5'd0, 12'd5, 32'h00500093);
    tick();
    @(negedge clk);
    chk("word_count_after_addi", {55'd0, word_count}, 1);
    tick();
    send(2'b01, 5'd0, 5'd1, 5'd2, 12'hFFE, 32'hFE209EE3);
    tick();
    @(negedge clk);
    chk("word_count_after_bne", {55'd0, word_count}, 2);
    tick();

    // Three descriptors then HALT
    do_start();
    nwr = 0;
    repeat (3) send_rand();
    send(2'b10, 5'd0, 5'd0, 5'd0, 12'd0, 32'd0);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("halt_writes", nwr, 3);
    chk("halt_done", {63'd0, done}, 1);
    chk("halt_full", {63'd0, full}, 0);
    chk("halt_ready", {63'd0, bus.in_ready}, 0);
    chk("halt_word_count", {55'd0, word_count}, 3);
    repeat (4) tick();
    @(negedge clk);
    chk("halt_done_held", {63'd0, done}, 1);
    chk("halt_no_more_writes", nwr, 3);
    tick();
    bus.in_valid = 1'b0;

    // Reserved op
    do_start();
    nwr = 0;
    send(2'b11, 5'd3, 5'd4, 5'd5, 12'h123, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    chk("rsvd_err", {63'd0, err}, 1);
    chk("rsvd_ready", {63'd0, bus.in_ready}, 0);
    chk("rsvd_no_write", nwr, 0);
    tick();
    do_start();
    @(negedge clk);
    chk("err_cleared", {63'd0, err}, 0);
    tick();
    send(2'b00, 5'd7, 5'd2, 5'd0, 12'h7FF, ref_addi(7, 2, 2047));
    tick();

    // start in the WRITE cycle aborts that write
    do_start();
    nwr = 0;
    send(2'b00, 5'd9, 5'd9, 5'd0, 12'h00A, ref_addi(9, 9, 10));
    do_start();
    send(2'b01, 5'd0, 5'd3, 5'd4, 12'h004, ref_bne(3, 4, 8));
    tick();
    @(negedge clk);
    chk("abort_writes", nwr, 1);
    chk("abort_word_count", {55'd0, word_count}, 1);
    tick();

    // Randomized program with idle gaps
    do_start();
    cnt = $urandom_range(25, 40);
    for (int i = 0; i < cnt; i++) begin
      send_rand();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    send(2'b10, 5'd0, 5'd0, 5'd0, 12'd0, 32'd0);
    tick();
    @(negedge clk);
    chk("rand_word_count", {55'd0, word_count}, cnt);
    chk("rand_done", {63'd0, done}, 1);
    tick();

    // rst in the middle of a load
    do_start();
    send_rand();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_state_ready", {63'd0, bus.in_ready}, 0);
    chk("midrst_wr_addr", {56'd0, wr_addr}, 0);
    chk("midrst_wr_data", {32'd0, wr_data}, 0);
    chk("midrst_word_count", {55'd0, word_count}, 0);
    chk("midrst_flags", {61'd0, done, full, err}, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("idle_ready_after_rst", {63'd0, bus.in_ready}, 0);
    tick();

    // Small memory: valid held high, capacity is 4 words
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    acc_s = 0;
    bus_s.in_op = 2'b00;
    bus_s.in_rd = 5'($urandom); bus_s.in_rs1 = 5'($urandom); bus_s.in_imm = 12'($urandom);
    bus_s.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus_s.in_ready) begin
        acc_s++;
        exp_qs.push_back('{addr: nxt_addr_s,
                           data: ref_addi(bus_s.in_rd, bus_s.in_rs1, int'(bus_s.in_imm))});
        nxt_addr_s++;
        tick();
        bus_s.in_rd = 5'($urandom); bus_s.in_rs1 = 5'($urandom); bus_s.in_imm = 12'($urandom);
      end else begin
        tick();
      end
    end
    @(negedge clk);
    chk("small_accepted", acc_s, 4);
    chk("small_writes", nwr_s, 4);
    chk("small_done", {63'd0, done_s}, 1);
    chk("small_full", {63'd0, full_s}, 1);
    chk("small_word_count", {61'd0, word_count_s}, 4);
    chk("small_ready", {63'd0, bus_s.in_ready}, 0);
    tick();
    bus_s.in_valid = 1'b0;

    chk("queue_drained", exp_q.size(), 0);
    chk("small_queue_drained", exp_qs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
